// File: rtl/regfile_seq_pkg.sv
// Shared encodings for the register-file operation sequencer.
// Opcodes, FSM states and default widths.
package regfile_seq_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 3;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer: (op, a, b) -> result.
// The carry output exists only when SEQ_FLAGS_EN is defined.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
`ifdef SEQ_FLAGS_EN
    ,
    output logic          carry
`endif
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = a << b[3:0];
            OP_SHR:  y = a >> b[3:0];
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

`ifdef SEQ_FLAGS_EN
    // A wrapped sum is smaller than either addend; a borrow occurs when a < b.
    always_comb begin
        carry = 1'b0;
        unique case (op)
            OP_ADD:  carry = (y < a);
            OP_SUB:  carry = (a < b);
            default: carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/regfile_op_sequencer.sv
// Drives an 8x16 register file: read operands, execute, write back.
// Optional flag outputs are enabled with SEQ_FLAGS_EN.
module regfile_op_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs0,
    input  logic [AW-1:0] cmd_rs1,
    output logic [AW-1:0] R_port0,
    output logic [AW-1:0] R_port1,
    input  logic [DW-1:0] Read0,
    input  logic [DW-1:0] Read1,
    output logic          WE,
    output logic [AW-1:0] W_port,
    output logic [DW-1:0] Write,
    output logic          done
`ifdef SEQ_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_n
`endif
);

    state_e        state;
    state_e        state_nx;
    op_e           op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] res_q;
    logic [AW-1:0] wp_q;
    logic [DW-1:0] alu_y;
    logic          accept;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (accept) state_nx = ST_READ;
            ST_READ:  state_nx = ST_EXEC;
            ST_EXEC:  state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

`ifdef SEQ_FLAGS_EN
    logic alu_c;

    seq_alu #(.DW(DW)) u_alu (
        .op    (op_q),
        .a     (op_a),
        .b     (op_b),
        .y     (alu_y),
        .carry (alu_c)
    );
`else
    seq_alu #(.DW(DW)) u_alu (
        .op (op_q),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );
`endif

    // Write strobe decodes straight from the state flop, so reset kills it at once.
    assign WE     = (state == ST_WRITE);
    assign done   = (state == ST_WRITE);
    assign W_port = wp_q;
    assign Write  = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            R_port0   <= '0;
            R_port1   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            wp_q      <= '0;
        end else begin
            cmd_ready <= (state_nx == ST_IDLE);
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                rd_q    <= cmd_rd;
                R_port0 <= cmd_rs0;
                R_port1 <= cmd_rs1;
            end
            if (state == ST_READ) begin
                op_a <= Read0;
                op_b <= Read1;
            end
            if (state == ST_EXEC) begin
                res_q <= alu_y;
                wp_q  <= rd_q;
            end
        end
    end

`ifdef SEQ_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == ST_EXEC) begin
            flag_z <= (alu_y == '0);
            flag_c <= alu_c;
            flag_n <= alu_y[DW-1];
        end
    end
`endif

endmodule
